contador_a: RTL and testbench
=============================

// Module: contador_a
// PURPOSE
//   Mode-selectable up/down/step/load counter driven by the mode-sequencing test benches.
//   Per clock it counts by +3, -1 or +1, or loads parallel data D, as selected by `mode`.
//   It flags a parallel load on `load` and a wrap or borrow on `rco`, for cascading.
//   Mode encodings are taken from src/defines.v.
// PARAMETERS
//   WIDTH  4  counter/data width in bits; all arithmetic is modulo 2**WIDTH
//   PASO   3  step size used in mode CUENTA_TRES_TRES
// PORTS
//   clk     input   1      single clock; all state changes on rising edge
//   reset   input   1      asynchronous, active-low reset (0 = reset)
//   enable  input   1      1 = operate per mode; 0 = hold Q
//   mode    input   2      00 CUENTA_TRES_TRES, 01 CUENTA_MENOS_UNO, 10 CUENTA_MAS_UNO, 11 CARGA_D
//   D       input   WIDTH  parallel load value, sampled only in CARGA_D
//   Q       output  WIDTH  registered count value
//   rco     output  1      registered; 1 for one cycle when Q wraps or borrows
//   load    output  1      registered; 1 for one cycle after a load edge
// BEHAVIOUR
//   Reset (reset==0, asynchronous):
//   - Q=0, rco=0, load=0 immediately, with no clock needed.
//   - Release is sampled at the next rising edge; that edge already operates per enable and mode.
//   enable==0 at an edge:
//   - Q holds, rco<=0, load<=0, and mode and D are ignored.
//   enable==1 at an edge; all outputs update together, with 1-cycle latency from mode/D sample to Q:
//   - 00: Q<=Q+PASO (mod 2**WIDTH). rco<=1 iff Q+PASO >= 2**WIDTH (e.g. 13..15 -> 0..2). load<=0.
//   - 01: Q<=Q-1. rco<=1 iff Q==0 (borrow, 0 -> 2**WIDTH-1). load<=0.
//   - 10: Q<=Q+1. rco<=1 iff Q==2**WIDTH-1 (wrap to 0). load<=0.
//   - 11: Q<=D. rco<=0. load<=1.
//   rco and load rules:
//   - rco and load are never both 1 in the same cycle.
//   - rco is cleared on every edge where the condition is false, so it is a pulse, not sticky.
//   - While mode stays 11, load stays 1 every cycle and Q tracks D with one cycle of delay.
//   Mode changes:
//   - A change takes effect at the first edge that samples it, with no idle or transition cycle.
//   - Q continues from its current value; there is no implicit reset on a mode change.
//   Reset asserted mid-operation:
//   - Overrides everything, including a pending wrap or load.
//   - Q, rco and load go to 0 without waiting for an edge.
//   Edge cases:
//   - X/Z on mode while enable==1 is not supported and the result is undefined.
//   - There is no internal state beyond Q, rco and load; no FSM memory survives a mode switch.
// TESTING
//   1 Reset: reset=0 with Q=9 mid-count -> Q=0, rco=0, load=0 before the next edge.
//     Release with enable=1, mode=10 -> Q=1 after the first edge.
//   2 Mode 00 from Q=0, 6 edges -> Q = 3,6,9,12,15,2.
//     rco=1 only in the cycle Q=2; load=0 throughout.
//   3 Mode 01 from Q=1, 3 edges -> Q = 0,15,14.
//     rco=1 only in the cycle Q=15.
//   4 Mode 10 from Q=14, 3 edges -> Q = 15,0,1.
//     rco=1 only in the cycle Q=0.
//   5 Mode 11 with D=4'hA, then D=4'h5 -> Q=A then 5, load=1 both cycles, rco=0.
//     Switch to mode 10 -> Q=6, load=0.
//   6 enable=0 for 5 edges at Q=7 in any mode -> Q stays 7, rco=0, load=0.
//     Re-enable in mode 00 -> Q=10.

Source files
------------

// File: rtl/contador_a.sv
// Mode-selectable counter: step by +PASO, count down, count up, or parallel load.
// rco pulses on wrap/borrow and load pulses on each load edge, both registered with Q.
module contador_a #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PASO  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load
);

    typedef enum logic [1:0] {
        CuentaTresTres  = 2'b00,
        CuentaMenosUno  = 2'b01,
        CuentaMasUno    = 2'b10,
        CargaD          = 2'b11
    } mode_e;

    localparam logic [WIDTH:0]   StepExt = (WIDTH + 1)'(PASO);
    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

    mode_e            mode_sel;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] q_d;
    logic             rco_d;
    logic             load_d;

    assign mode_sel = mode_e'(mode);

    // One extra bit so the carry out of Q+PASO directly gives the wrap flag.
    assign step_sum = {1'b0, Q} + StepExt;

    always_comb begin
        q_d    = Q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (enable) begin
            case (mode_sel)
                CuentaTresTres: begin
                    q_d   = step_sum[WIDTH-1:0];
                    rco_d = step_sum[WIDTH];
                end
                CuentaMenosUno: begin
                    q_d   = Q - 1'b1;
                    rco_d = (Q == '0);
                end
                CuentaMasUno: begin
                    q_d   = Q + 1'b1;
                    rco_d = (Q == AllOnes);
                end
                CargaD: begin
                    q_d    = D;
                    load_d = 1'b1;
                end
                default: begin
                    q_d = Q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else begin
            Q    <= q_d;
            rco  <= rco_d;
            load <= load_d;
        end
    end

endmodule

// File: tb/tb_contador_a.sv
// Directed bench for contador_a: reset, each mode, wrap/borrow pulses, load, and hold.
module tb_contador_a;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             rco;
    logic             load;

    int checks = 0;
    int errors = 0;

    contador_a #(.WIDTH(WIDTH), .PASO(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .D      (D),
        .Q      (Q),
        .rco    (rco),
        .load   (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] eq,
                             input logic er, input logic el);
        check({tag, ".Q"}, 32'(Q), 32'(eq));
        check({tag, ".rco"}, 32'(rco), 32'(er));
        check({tag, ".load"}, 32'(load), 32'(el));
    endtask

    // Apply inputs, take one rising edge, then sample 1 time unit later.
    task automatic step(input logic en, input logic [1:0] m, input logic [WIDTH-1:0] d,
                        input string tag, input logic [WIDTH-1:0] eq,
                        input logic er, input logic el);
        enable = en;
        mode   = m;
        D      = d;
        @(posedge clk);
        #1;
        check_all(tag, eq, er, el);
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        mode   = 2'b00;
        D      = '0;
        #2;
        check_all("por", 4'd0, 1'b0, 1'b0);

        // Test 1: async reset mid-count from Q=9, then release into mode 10
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 2'b11, 4'd9, "t1_load9", 4'd9, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("t1_async", 4'd0, 1'b0, 1'b0);
        enable = 1'b1;
        mode   = 2'b10;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 2'b10, 4'd0, "t1_rel", 4'd1, 1'b0, 1'b0);

        // Test 2: mode 00 from 0
        step(1'b1, 2'b11, 4'd0, "t2_ld0", 4'd0, 1'b0, 1'b1);
        step(1'b1, 2'b00, 4'd0, "t2_s1", 4'd3,  1'b0, 1'b0);
        step(1'b1, 2'b00, 4'd0, "t2_s2", 4'd6,  1'b0, 1'b0);
        step(1'b1, 2'b00, 4'd0, "t2_s3", 4'd9,  1'b0, 1'b0);
        step(1'b1, 2'b00, 4'd0, "t2_s4", 4'd12, 1'b0, 1'b0);
        step(1'b1, 2'b00, 4'd0, "t2_s5", 4'd15, 1'b0, 1'b0);
        step(1'b1, 2'b00, 4'd0, "t2_s6", 4'd2,  1'b1, 1'b0);

        // Test 3: mode 01 from 1
        step(1'b1, 2'b11, 4'd1, "t3_ld1", 4'd1, 1'b0, 1'b1);
        step(1'b1, 2'b01, 4'd0, "t3_s1", 4'd0,  1'b0, 1'b0);
        step(1'b1, 2'b01, 4'd0, "t3_s2", 4'd15, 1'b1, 1'b0);
        step(1'b1, 2'b01, 4'd0, "t3_s3", 4'd14, 1'b0, 1'b0);

        // Test 4: mode 10 from 14
        step(1'b1, 2'b10, 4'd0, "t4_s1", 4'd15, 1'b0, 1'b0);
        step(1'b1, 2'b10, 4'd0, "t4_s2", 4'd0,  1'b1, 1'b0);
        step(1'b1, 2'b10, 4'd0, "t4_s3", 4'd1,  1'b0, 1'b0);

        // Test 5: continuous load, then switch to count up
        step(1'b1, 2'b11, 4'hA, "t5_ldA", 4'hA, 1'b0, 1'b1);
        step(1'b1, 2'b11, 4'h5, "t5_ld5", 4'h5, 1'b0, 1'b1);
        step(1'b1, 2'b10, 4'h0, "t5_up",  4'h6, 1'b0, 1'b0);

        // Test 6: hold with enable low in varied modes, then resume in mode 00
        step(1'b1, 2'b11, 4'd7, "t6_ld7", 4'd7, 1'b0, 1'b1);
        step(1'b0, 2'b00, 4'd3, "t6_h0", 4'd7, 1'b0, 1'b0);
        step(1'b0, 2'b01, 4'd3, "t6_h1", 4'd7, 1'b0, 1'b0);
        step(1'b0, 2'b10, 4'd3, "t6_h2", 4'd7, 1'b0, 1'b0);
        step(1'b0, 2'b11, 4'd3, "t6_h3", 4'd7, 1'b0, 1'b0);
        step(1'b0, 2'b11, 4'd3, "t6_h4", 4'd7, 1'b0, 1'b0);
        step(1'b1, 2'b00, 4'd3, "t6_run", 4'd10, 1'b0, 1'b0);

        // Reset overrides a pending wrap at Q=15 and clears rco without an edge
        step(1'b1, 2'b11, 4'd15, "t7_ld15", 4'd15, 1'b0, 1'b1);
        step(1'b1, 2'b10, 4'd0, "t7_wrap", 4'd0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("t7_rst", 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("t7_hold", 4'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
